// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: 2-flop synchroniser, shared tick prescaler,
// per-channel lockout (MODE 0) or stability (MODE 1) filter with rise/fall pulses.
// Define DEBOUNCE_HOLD_EN to add per-channel long-press (switch_hold) detection.
module debounce_multi #(
    parameter int CHANNELS     = 4,
    parameter int BOUNCE_LIMIT = 600000,
    parameter int TICK_DIV     = 1,
    parameter int MODE         = 0,
    parameter bit INIT_LEVEL   = 1'b0,
    parameter int HOLD_LIMIT   = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] switch_in,
    output logic [CHANNELS-1:0] switch_out,
    output logic [CHANNELS-1:0] switch_rise,
    output logic [CHANNELS-1:0] switch_fall,
    output logic                any_event,
    output logic [CHANNELS-1:0] switch_hold
);

    localparam int CW = $clog2(BOUNCE_LIMIT + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LIMIT  = CW'(BOUNCE_LIMIT);
    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] RELOAD = (MODE == 1) ? LIMIT : ZERO;
    localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL}};

    if (CHANNELS < 1 || BOUNCE_LIMIT < 1 || TICK_DIV < 1 || HOLD_LIMIT < 1) begin : g_bad_params
        $error("debounce_multi: CHANNELS, BOUNCE_LIMIT, TICK_DIV and HOLD_LIMIT must be >= 1");
    end

    logic [CHANNELS-1:0] s1_r;
    logic [CHANNELS-1:0] s2_r;
    logic [CHANNELS-1:0] out_r;
    logic [CHANNELS-1:0] rise_r;
    logic [CHANNELS-1:0] fall_r;
    logic [CHANNELS-1:0] out_nxt_s;
    logic [CHANNELS-1:0] rise_nxt_s;
    logic [CHANNELS-1:0] fall_nxt_s;
    logic [CW-1:0]       cnt_r     [CHANNELS];
    logic [CW-1:0]       cnt_nxt_s [CHANNELS];
    logic [PW-1:0]       pcnt_r;
    logic                tick_s;

    // With TICK_DIV=1 the terminal count is 0, so the prescaler sits at 0 and tick stays high.
    assign tick_s = (pcnt_r == PW'(TICK_DIV - 1));

    // Shared prescaler counting 0..TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_r <= {PW{1'b0}};
        end else if (tick_s) begin
            pcnt_r <= {PW{1'b0}};
        end else begin
            pcnt_r <= pcnt_r + PW'(1);
        end
    end

    // Two-flop synchroniser for the raw pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= INIT_VEC;
            s2_r <= INIT_VEC;
        end else begin
            s1_r <= switch_in;
            s2_r <= s1_r;
        end
    end

    // Per-channel filter next-state: lockout or stability counter.
    always_comb begin : p_filter
        logic accept_v;
        for (int i = 0; i < CHANNELS; i++) begin
            accept_v      = 1'b0;
            out_nxt_s[i]  = out_r[i];
            rise_nxt_s[i] = 1'b0;
            fall_nxt_s[i] = 1'b0;
            cnt_nxt_s[i]  = cnt_r[i];
            if (MODE == 0) begin
                if (cnt_r[i] == ZERO) begin
                    accept_v = (s2_r[i] != out_r[i]);
                end else if (tick_s) begin
                    cnt_nxt_s[i] = cnt_r[i] - CW'(1);
                end else begin
                    cnt_nxt_s[i] = cnt_r[i];
                end
            end else begin
                if (s2_r[i] == out_r[i]) begin
                    cnt_nxt_s[i] = LIMIT;
                end else if (tick_s) begin
                    if (cnt_r[i] == ZERO) begin
                        accept_v = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] - CW'(1);
                    end
                end else begin
                    cnt_nxt_s[i] = cnt_r[i];
                end
            end
            if (accept_v) begin
                out_nxt_s[i]  = s2_r[i];
                rise_nxt_s[i] = s2_r[i];
                fall_nxt_s[i] = ~s2_r[i];
                cnt_nxt_s[i]  = LIMIT;
            end else begin
                out_nxt_s[i]  = out_r[i];
            end
        end
    end

    // Filter state and registered level/pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r  <= INIT_VEC;
            rise_r <= {CHANNELS{1'b0}};
            fall_r <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= RELOAD;
            end
        end else begin
            out_r  <= out_nxt_s;
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign switch_out  = out_r;
    assign switch_rise = rise_r;
    assign switch_fall = fall_r;
    assign any_event   = |(rise_r | fall_r);

`ifdef DEBOUNCE_HOLD_EN
    localparam int HW = $clog2(HOLD_LIMIT + 1);

    logic [HW-1:0]       hcnt_r     [CHANNELS];
    logic [HW-1:0]       hcnt_nxt_s [CHANNELS];
    logic [CHANNELS-1:0] hold_r;
    logic [CHANNELS-1:0] hold_nxt_s;

    // Long-press counter: saturates at HOLD_LIMIT so the pulse fires once per press.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            hcnt_nxt_s[i] = hcnt_r[i];
            hold_nxt_s[i] = 1'b0;
            if (!out_r[i] || rise_nxt_s[i]) begin
                hcnt_nxt_s[i] = {HW{1'b0}};
            end else if (tick_s && (hcnt_r[i] < HW'(HOLD_LIMIT))) begin
                hcnt_nxt_s[i] = hcnt_r[i] + HW'(1);
                hold_nxt_s[i] = (hcnt_r[i] == HW'(HOLD_LIMIT - 1));
            end else begin
                hcnt_nxt_s[i] = hcnt_r[i];
            end
        end
    end

    // Hold counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                hcnt_r[i] <= {HW{1'b0}};
            end
        end else begin
            hold_r <= hold_nxt_s;
            for (int i = 0; i < CHANNELS; i++) begin
                hcnt_r[i] <= hcnt_nxt_s[i];
            end
        end
    end

    assign switch_hold = hold_r;
`else
    assign switch_hold = {CHANNELS{1'b0}};
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: a lockout instance driven from a vector
// table, plus hand sequences for stability mode, prescaling, reset and long-press.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw0, sw1, sw2;
    logic [3:0] out0, rise0, fall0, hold0;
    logic [3:0] out1, rise1, fall1, hold1;
    logic [3:0] out2, rise2, fall2, hold2;
    logic       any0, any1, any2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(4), .BOUNCE_LIMIT(5), .TICK_DIV(1), .MODE(0),
                     .INIT_LEVEL(1'b0), .HOLD_LIMIT(8)) dut0 (
        .clk(clk), .rst(rst), .switch_in(sw0), .switch_out(out0), .switch_rise(rise0),
        .switch_fall(fall0), .any_event(any0), .switch_hold(hold0));

    debounce_multi #(.CHANNELS(4), .BOUNCE_LIMIT(5), .TICK_DIV(1), .MODE(1),
                     .INIT_LEVEL(1'b0), .HOLD_LIMIT(8)) dut1 (
        .clk(clk), .rst(rst), .switch_in(sw1), .switch_out(out1), .switch_rise(rise1),
        .switch_fall(fall1), .any_event(any1), .switch_hold(hold1));

    debounce_multi #(.CHANNELS(4), .BOUNCE_LIMIT(3), .TICK_DIV(4), .MODE(1),
                     .INIT_LEVEL(1'b0), .HOLD_LIMIT(8)) dut2 (
        .clk(clk), .rst(rst), .switch_in(sw2), .switch_out(out2), .switch_rise(rise2),
        .switch_fall(fall2), .any_event(any2), .switch_hold(hold2));

    typedef struct {
        logic [3:0] sw;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input int step, input logic [3:0] act,
                       input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the last reset edge (edge 0).
    task automatic do_reset();
        rst = 1'b1;
        sw0 = 4'b0000;
        sw1 = 4'b0000;
        sw2 = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Row i input is driven after edge i; outputs checked after edge i+1.
        tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[2]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[4]  = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b1};
        tbl[5]  = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0};
        tbl[6]  = '{4'b1010, 4'b1000, 4'b0000, 4'b0000, 1'b0};
        tbl[7]  = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0};
        tbl[8]  = '{4'b1010, 4'b1010, 4'b0010, 4'b0000, 1'b1};
        tbl[9]  = '{4'b1000, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        tbl[10] = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        tbl[11] = '{4'b0011, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        tbl[12] = '{4'b0011, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        tbl[13] = '{4'b0011, 4'b0011, 4'b0001, 4'b1000, 1'b1};
        tbl[14] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 1'b0};
        tbl[15] = '{4'b0010, 4'b0011, 4'b0000, 4'b0000, 1'b0};
        tbl[16] = '{4'b0010, 4'b0011, 4'b0000, 4'b0000, 1'b0};
        tbl[17] = '{4'b0010, 4'b0011, 4'b0000, 4'b0000, 1'b0};
        tbl[18] = '{4'b0010, 4'b0011, 4'b0000, 4'b0000, 1'b0};
        tbl[19] = '{4'b0010, 4'b0010, 4'b0000, 4'b0001, 1'b1};
        tbl[20] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0};

        // Reset state of every instance.
        do_reset();
        chk("rst_out0", 0, out0, 4'b0000);
        chk("rst_pulse0", 0, rise0 | fall0 | hold0, 4'b0000);
        chk("rst_out1", 0, out1, 4'b0000);
        chk("rst_out2", 0, out2, 4'b0000);
        chk("rst_any", 0, {1'b0, any0, any1, any2}, 4'b0000);

        // Lockout filter vector table.
        for (int i = 0; i < 21; i++) begin
            sw0 = tbl[i].sw;
            @(posedge clk);
            #1;
            chk("lk_out", i, out0, tbl[i].out);
            chk("lk_rise", i, rise0, tbl[i].rise);
            chk("lk_fall", i, fall0, tbl[i].fall);
            chk("lk_any", i, {3'b000, any0}, {3'b000, tbl[i].any});
        end

        // Stability filter: ch2 high 4 cycles, low 1, then high; accepted 8 clocks after re-rise.
        do_reset();
        sw1 = 4'b0100;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            chk("st_out", e, out1, {1'b0, e >= 13, 2'b00});
            chk("st_rise", e, rise1, {1'b0, e == 13, 2'b00});
            chk("st_fall", e, fall1, 4'b0000);
            sw1 = (e == 4) ? 4'b0000 : 4'b0100;
        end

        // Prescaled stability filter: ticks on edges 4,8,..; change at s2 on edge 12 lands on edge 28.
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #1;
            chk("ps_out", e, out2, {3'b000, e >= 28});
            chk("ps_rise", e, rise2, {3'b000, e == 28});
            chk("ps_any", e, {3'b000, any2}, {3'b000, e == 28});
            if (e == 10) sw2 = 4'b0001;
        end

        // Reset in the middle of a lockout: count is abandoned, no spurious pulse.
        do_reset();
        sw0 = 4'b0001;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            chk("rl_out", e, out0, {3'b000, (e == 3) || (e >= 7)});
            chk("rl_rise", e, rise0, {3'b000, (e == 3) || (e == 7)});
            chk("rl_fall", e, fall0, 4'b0000);
            rst = (e == 3);
        end

        // Long press, release and re-press on ch0.
        do_reset();
        sw0 = 4'b0001;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk);
            #1;
            chk("hp_out", e, out0, {3'b000, ((e >= 3) && (e < 23)) || (e >= 33)});
`ifdef DEBOUNCE_HOLD_EN
            chk("hp_hold", e, hold0, {3'b000, (e == 11) || (e == 41)});
`else
            chk("hp_hold", e, hold0, 4'b0000);
`endif
            sw0 = ((e >= 20) && (e < 30)) ? 4'b0000 : 4'b0001;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel switch/button debouncer for board-level inputs (buttons, DIP switches, encoders).
- Each channel has a 2-flop synchroniser, a per-channel bounce counter and a registered clean level with one-cycle rise/fall pulses.
- Two filter modes are selectable: lockout (accept the first edge, then ignore the input) and stability (accept a change only once it has held).
- A shared prescaler lets long debounce times use narrow counters. Sits between the input pins and the user logic.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- BOUNCE_LIMIT, 600000, debounce time in prescaler ticks (>=1).
- TICK_DIV, 1, clocks per prescaler tick (>=1); 1 = tick every cycle.
- MODE, 0, 0 = lockout filter, 1 = stability filter.
- INIT_LEVEL, 0, reset value of synchroniser and clean level (applied to all channels).
- HOLD_LIMIT, 1000, long-press threshold in ticks (optional feature only).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- switch_in  in  CHANNELS  raw asynchronous inputs.
- switch_out  out  CHANNELS  debounced level.
- switch_rise  out  CHANNELS  one-cycle pulse, clean 0->1.
- switch_fall  out  CHANNELS  one-cycle pulse, clean 1->0.
- any_event  out  1  combinational OR of all rise|fall bits.
- switch_hold  out  CHANNELS  long-press pulse (optional feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - sync stages and switch_out = {CHANNELS{INIT_LEVEL}}.
  - rise/fall/hold = 0.
  - prescaler = 0.
  - counters = 0 (MODE 0) or BOUNCE_LIMIT (MODE 1).
  - Reset mid-bounce abandons the count; no pulse is emitted on the reset cycle or on the cycle after it.
- Synchroniser: s1<=switch_in; s2<=s1. s2 is the only input the filter sees.
- Prescaler:
  - pcnt counts 0..TICK_DIV-1 and wraps.
  - tick=1 when pcnt==TICK_DIV-1.
  - TICK_DIV=1 gives tick tied high.
  - Width is $clog2(TICK_DIV) with a minimum of 1.
- Counter width: $clog2(BOUNCE_LIMIT+1). The counter never underflows.
- MODE 0, lockout, per channel:
  - cnt==0 and s2!=out: out<=s2, pulse rise/fall, cnt<=BOUNCE_LIMIT.
  - cnt!=0: input ignored; cnt decrements on tick.
  - When cnt reaches 0 and s2 differs, the change is accepted on the next clock.
  - Latency, input edge to switch_out: 3 clocks.
- MODE 1, stability, per channel:
  - s2==out: cnt<=BOUNCE_LIMIT (reload every clock).
  - s2!=out on a tick: if cnt==0, out<=s2, pulse, cnt<=BOUNCE_LIMIT; otherwise cnt decrements.
  - s2!=out without a tick: cnt holds.
  - Acceptance requires a difference held for BOUNCE_LIMIT+1 ticks. Any glitch back to out reloads the counter.
- Pulses:
  - Registered; asserted in the same cycle switch_out changes; exactly 1 cycle wide.
  - rise and fall of one channel are never both high.
- Channels are fully independent; simultaneous events on several channels each produce their own pulses.
- All outputs are registered except any_event.

Optional Feature:
- Macro: DEBOUNCE_HOLD_EN.
- Defined:
  - Per-channel hold counter, width $clog2(HOLD_LIMIT+1).
  - Cleared when out==0 or on a rise.
  - Increments on tick while out==1 and below HOLD_LIMIT.
  - switch_hold pulses one cycle when the count reaches HOLD_LIMIT; no repeat until released.
  - Reset clears the counter and output.
- Not defined: switch_hold tied to 0, no hold counters synthesised; the port remains for a stable interface.

Test Plan:
- CHANNELS=4, MODE=0, BOUNCE_LIMIT=5, TICK_DIV=1; ch0 0->1 at cycle 10 -> switch_out[0]=1 and switch_rise[0]=1 at cycle 13 only; any_event=1 at cycle 13.
- MODE=0; ch1 toggles 0,1,0,1 every clock from cycle 10 then stays 1 -> single rise at cycle 13; no further pulse; switch_out[1]=1 after the lockout expires.
- MODE=1, BOUNCE_LIMIT=5; ch2 high for 4 cycles, low for 1, then high -> no event until 6 consecutive high ticks after s2 stays high; exactly one rise.
- TICK_DIV=4, MODE=1, BOUNCE_LIMIT=3; steady input change -> accepted 16 +/- 3 clocks after s2 changes; pcnt wraps 3->0.
- ch0 rise and ch3 fall on the same clock -> both pulses in the same cycle; rst asserted mid-lockout -> outputs return to INIT_LEVEL/0 next cycle, with no spurious pulse.
- DEBOUNCE_HOLD_EN, HOLD_LIMIT=8, TICK_DIV=1; ch0 held high -> switch_hold[0] single pulse 8 clocks after the rise; a release and re-press re-arms it.
